// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
// Holds the sequencer state encoding, the 2-bit opcode values and a small
// helper that identifies the states waiting on the memory handshake.
package ctrl_pkg;

    // Sequencer states; ERROR is terminal until reset.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] OP_RTYPE  = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    // True in the states that hold a memory request open until mem_ready.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles a memory request has been
// outstanding without mem_ready and flags a timeout on the last allowed
// wait cycle, so the sequencer can enter ERROR on the following edge.
// A ready in the same cycle always suppresses the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic ready_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] wait_cnt_q;
    logic [W-1:0] wait_cnt_d;
    logic         waiting_s;

    assign waiting_s = active_i && !ready_i;
    assign timeout_o = waiting_s && (wait_cnt_q == LIMIT);

    // Next count: grow while waiting, restart on ready, idle or state change.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!waiting_s || clear_i) begin
            wait_cnt_d = {W{1'b0}};
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= {W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 2-bit-opcode CPU. Sequences the shared
// ALU/memory datapath through FETCH/DECODE/EXEC/MEM/WB with a memory ready
// handshake and a sticky timeout error. Outputs are a Moore decode of the
// state and latched opcode; in FETCH/MEM the handshake-qualified enables
// are additionally gated by mem_ready (and pc_write by zero in EXEC).
// Optional build macro: MCS_PERF_CNT_EN adds saturating instruction and
// busy-cycle counters; without it both counter outputs are tied to zero.
module multicycle_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             instr_done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] op_q;
    logic [1:0] op_d;
    logic       timeout_s;
    logic       end_instr_s;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .active_i  (is_mem_wait_state(state_q)),
        .ready_i   (mem_ready),
        .clear_i   (state_d != state_q),
        .timeout_o (timeout_s)
    );

    // State and latched opcode registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic and Moore output decode with handshake gating.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        end_instr_s = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        alu_op      = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        busy        = 1'b0;
        instr_done  = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b0;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 1'b0;
                    state_d  = DECODE;
                end else if (timeout_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                busy    = 1'b1;
                op_d    = op;
                state_d = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                case (op_q)
                    OP_RTYPE: begin
                        alu_op  = 1'b1;
                        state_d = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    OP_BRANCH: begin
                        pc_src      = 1'b1;
                        pc_write    = zero;
                        instr_done  = 1'b1;
                        end_instr_s = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            MEM: begin
                busy = 1'b1;
                case (op_q)
                    OP_LOAD: begin
                        mem_read = 1'b1;
                        iord     = 1'b1;
                        if (mem_ready) begin
                            state_d = WB;
                        end else if (timeout_s) begin
                            state_d = ERROR;
                        end else begin
                            state_d = MEM;
                        end
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        iord      = 1'b1;
                        if (mem_ready) begin
                            instr_done  = 1'b1;
                            end_instr_s = 1'b1;
                        end else if (timeout_s) begin
                            state_d = ERROR;
                        end else begin
                            state_d = MEM;
                        end
                    end
                    default: begin
                        // R-type and branch never reach MEM; recover to IDLE.
                        state_d = IDLE;
                    end
                endcase
            end
            WB: begin
                busy        = 1'b1;
                reg_write   = 1'b1;
                instr_done  = 1'b1;
                end_instr_s = 1'b1;
                if (op_q == OP_LOAD) begin
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b1;
                end else begin
                    reg_dst    = 1'b1;
                    mem_to_reg = 1'b0;
                end
            end
            ERROR: begin
                err     = 1'b1;
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // run is only sampled at an instruction boundary, so a drop of run
        // mid-instruction lets the current instruction retire first.
        if (end_instr_s) begin
            if (run) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_d;
        end
    end

`ifdef MCS_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] instr_count_q;
    logic [CNT_W-1:0] instr_count_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;

    // Saturating increments of the retired-instruction and busy-cycle counts.
    always_comb begin
        instr_count_d = instr_count_q;
        cycle_count_d = cycle_count_q;
        if (instr_done && (instr_count_q != CNT_MAX)) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end else begin
            instr_count_d = instr_count_q;
        end
        if (busy && (cycle_count_q != CNT_MAX)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end else begin
            cycle_count_d = cycle_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_q <= {CNT_W{1'b0}};
            cycle_count_q <= {CNT_W{1'b0}};
        end else begin
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign cycle_count = cycle_count_q;
`else
    assign instr_count = {CNT_W{1'b0}};
    assign cycle_count = {CNT_W{1'b0}};
`endif

endmodule
